sha2_message_pad: RTL
=====================

# sha2_message_pad

Parametrised SHA-2 message padder: accepts a per-message config (bit length, tag) followed by block-wide message words, and emits fully padded SHA-2 blocks (data, `1` end marker, zero fill, big-endian length field) to the hash core. Generalises the SHA-256 message builder to SHA-224/256 (512-bit block, 64-bit length) and SHA-384/512 (1024-bit block, 128-bit length). It also adds zero-length messages, a correct end marker for block-multiple lengths, message-tag passthrough, full-throughput handshakes and input framing-error detection. Sits between the input DMA/FIFO and the hash-round engine.

## Interface
- `BLOCK_W`, 512: block width in bits; legal values 512 or 1024.
- `LEN_W`, 64: length field width in bits; 64 for `BLOCK_W=512`, 128 for `BLOCK_W=1024`.
- `ID_W`, 4: message tag width.
- `clk` in 1: single clock.
- `nrst` in 1: asynchronous, active-low reset.
- `en` in 1: clock enable; low freezes all state.
- `sync_rst` in 1: synchronous clear to reset state; takes priority over `en`.
- `cfg_size` in LEN_W: message length L in bits.
- `cfg_id` in ID_W: message tag.
- `cfg_valid` in 1, `cfg_ready` out 1: config handshake.
- `data_in` in BLOCK_W: message word; first message bit is at bit BLOCK_W-1.
- `data_in_last` in 1: source's end-of-message flag.
- `data_in_valid` in 1, `data_in_ready` out 1: input handshake.
- `data_out` out BLOCK_W: padded block.
- `data_out_id` out ID_W: tag of the current message.
- `data_out_last` out 1: final block of the message.
- `data_out_valid` out 1, `data_out_ready` in 1: output handshake.
- `len_err` out 1: one-cycle framing-error pulse.

## Operation
- Derived values, latched at config accept:
  - R = L mod BLOCK_W (log2(BLOCK_W) bits).
  - N = ceil(L/BLOCK_W), the number of input words (LEN_W-log2(BLOCK_W)+1 bits).
  - N=0 when L=0.
- States:
  - **IDLE**: `cfg_ready=en`. On a config handshake, latch L, R, N and tag. Go to EXTRA if N=0, DATA if N>1, else LAST.
  - **DATA**: each accepted word is copied unchanged to the output register with last=0. Decrement the remaining count. Go to LAST when the remaining count reaches 1.
  - **LAST**: the accepted word is masked to its top R bits (no mask if R=0). If R≠0, bit BLOCK_W-1-R is set to 1.
    - If R≠0 and R ≤ BLOCK_W-LEN_W-1: OR L into the low LEN_W bits, set last=1, go to IDLE.
    - Otherwise: last=0, go to EXTRA.
  - **EXTRA**: no input is consumed. When the output slot is free, load the block {marker, zeros, L}, where marker=1 in bit BLOCK_W-1 iff R=0 (this covers L=0). Set last=1, go to IDLE.
- Slot free: `free = !out_valid_q || data_out_ready`.
- `data_in_ready = en && (state==DATA||LAST) && free` (combinational; no bubble).
- Output register loads only on en && free, either from an accepted input word or from the EXTRA block.
- `data_out_valid = out_valid_q && en`. A transfer is counted only while en=1.
- `data_out_id` holds the latched tag for every block of the message.
- `len_err` pulses for one cycle on an accepted word in either case:
  - `data_in_last=1` in DATA.
  - `data_in_last=0` in LAST.
- Padding always follows `cfg_size`; the data stream is not resynchronised by `data_in_last`.
- Unused upper bits of `cfg_size` beyond the SHA-2 maximum are padded as given; no check is made.

## Timing
- Reset values (`nrst` low or `sync_rst`):
  - state=IDLE, `out_valid_q=0`, `data_out=0`, `data_out_last=0`, `data_out_id=0`, `len_err=0`.
  - `data_in_ready=0`.
  - `cfg_ready` follows `en`.
- Latency:
  - Config accepted at cycle t gives `data_in_ready` possible at t+1.
  - Input word accepted at t appears on `data_out` at t+1.
  - EXTRA block appears the cycle after LAST's block is loaded, provided the slot is free.
  - L=0: padding block is valid at t+2 after config accept.
- Throughput: one block per cycle with `data_out_ready` held high.
- The next config can be accepted in the cycle after last=1 is loaded.
- Stall: while `data_out_valid && !data_out_ready`, `data_out`, `data_out_last` and `data_out_id` are stable and `data_in_ready=0`.
- `en` low mid-message: state and the output register hold; `cfg_ready`, `data_in_ready` and `data_out_valid` read 0; operation resumes exactly when `en` returns.
- Async reset mid-message discards the partial message. No block is emitted after reset until a new config is accepted.

## Test plan
- L=24 ("abc" in bits 511:488 = 0x616263), BLOCK_W=512 -> one block: 0x61626380, zero fill, low 64 bits = 0x18; last=1; id echoed.
- L=448, one word -> block 1: top 448 bits kept, bit 63 set, last=0; block 2: all zero except low 64 bits = 0x1C0, last=1.
- L=1024 (R=0), two words -> both passed unchanged, last=0; block 3: bit 511=1, low 64 bits = 0x400, last=1.
- L=0 -> `data_in_ready` never asserts; single block with bit 511=1 and length 0, last=1, valid two cycles after config.
- L=1536, `data_out_ready` pattern 1,0,1,0…, `en` dropped for 3 cycles mid-stream -> exactly 4 blocks, in order, stable during stalls, no duplicates.
- BLOCK_W=1024, LEN_W=128, L=24 -> 0x61626380 at top, low 128 bits = 0x18. Also: `data_in_last=1` on word 1 of 3 gives one `len_err` pulse, and padding is still per L.

Source files
------------

// File: rtl/sha2_message_pad.sv
// SHA-2 message padder: turns a configured bit length plus raw message words into
// padded blocks (end marker, zero fill, big-endian length) for SHA-224/256/384/512.
module sha2_message_pad #(
  parameter int BLOCK_W = 512,
  parameter int LEN_W   = 64,
  parameter int ID_W    = 4
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               en,
  input  logic               sync_rst,
  input  logic [LEN_W-1:0]   cfg_size,
  input  logic [ID_W-1:0]    cfg_id,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [BLOCK_W-1:0] data_in,
  input  logic               data_in_last,
  input  logic               data_in_valid,
  output logic               data_in_ready,
  output logic [BLOCK_W-1:0] data_out,
  output logic [ID_W-1:0]    data_out_id,
  output logic               data_out_last,
  output logic               data_out_valid,
  input  logic               data_out_ready,
  output logic               len_err
);

  localparam int LOG_B = $clog2(BLOCK_W);
  localparam int CNT_W = LEN_W - LOG_B + 1;
  localparam logic [LOG_B-1:0] FIT_MAX = LOG_B'(BLOCK_W - LEN_W - 1);

  typedef enum logic [1:0] {IDLE, DATA, LAST, EXTRA} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LOG_B-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    outId_q, outId_d;
  logic [BLOCK_W-1:0] out_q, out_d;
  logic               outLast_q, outLast_d;
  logic               outValid_q, outValid_d;
  logic               lenErr_q, lenErr_d;

  logic               free;
  logic               cfgFire;
  logic               inFire;
  logic               load;
  logic [LOG_B-1:0]   cfgRem;
  logic [CNT_W-1:0]   cfgWords;
  logic [BLOCK_W-1:0] headMask;
  logic [BLOCK_W-1:0] marker;
  logic [BLOCK_W-1:0] topBit;
  logic [BLOCK_W-1:0] lenField;
  logic [BLOCK_W-1:0] lastBlock;
  logic               lastFits;

  assign free          = !outValid_q || data_out_ready;
  assign cfg_ready     = en && (state_q == IDLE);
  assign data_in_ready = en && ((state_q == DATA) || (state_q == LAST)) && free;
  assign cfgFire       = cfg_ready && cfg_valid;
  assign inFire        = data_in_ready && data_in_valid;

  assign cfgRem   = cfg_size[LOG_B-1:0];
  assign cfgWords = {1'b0, cfg_size[LEN_W-1:LOG_B]} + {{(CNT_W-1){1'b0}}, (cfgRem != '0)};

  // The final word keeps only its top R bits; the end marker sits right after them.
  assign topBit    = {1'b1, {(BLOCK_W-1){1'b0}}};
  assign headMask  = (rem_q == '0) ? {BLOCK_W{1'b1}} : ~({BLOCK_W{1'b1}} >> rem_q);
  assign marker    = (rem_q == '0) ? '0 : (topBit >> rem_q);
  assign lenField  = {{(BLOCK_W-LEN_W){1'b0}}, len_q};
  assign lastBlock = (data_in & headMask) | marker;
  assign lastFits  = (rem_q != '0) && (rem_q <= FIT_MAX);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    outId_d   = outId_q;
    out_d     = out_q;
    outLast_d = outLast_q;
    lenErr_d  = 1'b0;
    load      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfgFire) begin
          len_d = cfg_size;
          rem_d = cfgRem;
          cnt_d = cfgWords;
          id_d  = cfg_id;
          if (cfgWords == '0)
            state_d = EXTRA;
          else if (cfgWords == CNT_W'(1))
            state_d = LAST;
          else
            state_d = DATA;
        end
      end
      DATA: begin
        if (inFire) begin
          load      = 1'b1;
          out_d     = data_in;
          outLast_d = 1'b0;
          outId_d   = id_q;
          cnt_d     = cnt_q - CNT_W'(1);
          lenErr_d  = data_in_last;
          if (cnt_q == CNT_W'(2))
            state_d = LAST;
        end
      end
      LAST: begin
        if (inFire) begin
          load     = 1'b1;
          outId_d  = id_q;
          lenErr_d = !data_in_last;
          if (lastFits) begin
            out_d     = lastBlock | lenField;
            outLast_d = 1'b1;
            state_d   = IDLE;
          end else begin
            out_d     = lastBlock;
            outLast_d = 1'b0;
            state_d   = EXTRA;
          end
        end
      end
      EXTRA: begin
        // Marker lands here only for block-multiple lengths, which includes L=0.
        if (en && free) begin
          load      = 1'b1;
          out_d     = ((rem_q == '0) ? topBit : '0) | lenField;
          outLast_d = 1'b1;
          outId_d   = id_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load)
      outValid_d = 1'b1;
    else if (data_out_ready)
      outValid_d = 1'b0;
    else
      outValid_d = outValid_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      id_q       <= '0;
      outId_q    <= '0;
      out_q      <= '0;
      outLast_q  <= 1'b0;
      outValid_q <= 1'b0;
      lenErr_q   <= 1'b0;
    end else if (sync_rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      id_q       <= '0;
      outId_q    <= '0;
      out_q      <= '0;
      outLast_q  <= 1'b0;
      outValid_q <= 1'b0;
      lenErr_q   <= 1'b0;
    end else if (en) begin
      state_q    <= state_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      outId_q    <= outId_d;
      out_q      <= out_d;
      outLast_q  <= outLast_d;
      outValid_q <= outValid_d;
      lenErr_q   <= lenErr_d;
    end
  end

  assign data_out       = out_q;
  assign data_out_id    = outId_q;
  assign data_out_last  = outLast_q;
  assign data_out_valid = outValid_q && en;
  assign len_err        = lenErr_q && en;

endmodule
